// File: rtl/sr_reg_dump.sv
// Walks the core debug port over [FIRST_REG..LAST_REG] and sends each register as a 5-byte UART 8N1 frame.
// Latency: one register takes 50*CLK_DIV+1 cycles (1 setup + 50 bits); tx is registered, first start bit one cycle after start.
// Backpressure: none; start is ignored while busy and the serial line is never stalled.
module sr_reg_dump #(
  parameter int CLK_DIV   = 4,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int              DW         = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [4:0]      ADDR_FIRST = 5'(FIRST_REG);
  localparam logic [4:0]      ADDR_LAST  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SEND
  } state_t;

  state_t        state, stateNext;
  logic [39:0]   frame, frameNext;      // byte being sent always sits in [39:32]
  logic [DW-1:0] divCnt, divNext;       // cycles spent in the current bit
  logic [3:0]    bitCnt, bitNext;       // 0 = start, 1..8 = data LSB first, 9 = stop
  logic [2:0]    byteCnt, byteNext;     // 0 = address byte, 1..4 = data MSB first
  logic [4:0]    addrNext;
  logic          txNext, busyNext, doneNext;
  logic [7:0]    curByte;

  assign curByte = frame[39:32];

  // State register: reset aborts any dump immediately and forces the line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      frame   <= '0;
      divCnt  <= '0;
      bitCnt  <= '0;
      byteCnt <= '0;
      regAddr <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= stateNext;
      frame   <= frameNext;
      divCnt  <= divNext;
      bitCnt  <= bitNext;
      byteCnt <= byteNext;
      regAddr <= addrNext;
      tx      <= txNext;
      busy    <= busyNext;
      done    <= doneNext;
    end
  end

  // Next-state logic: the registered tx is always computed one bit ahead of the boundary.
  always_comb begin
    stateNext = state;
    frameNext = frame;
    divNext   = divCnt;
    bitNext   = bitCnt;
    byteNext  = byteCnt;
    addrNext  = regAddr;
    txNext    = tx;
    busyNext  = busy;
    doneNext  = 1'b0;

    case (state)
      IDLE: begin
        txNext = 1'b1;
        // a start overlapping the done pulse belongs to the old dump and is dropped
        if (start && !done) begin
          stateNext = SETUP;
          addrNext  = ADDR_FIRST;
          busyNext  = 1'b1;
        end
      end

      SETUP: begin
        // regAddr has been stable a full cycle, so regData is sampled here exactly once
        frameNext = {3'b000, regAddr, regData};
        txNext    = 1'b0;
        divNext   = '0;
        bitNext   = 4'd0;
        byteNext  = 3'd0;
        stateNext = SEND;
      end

      SEND: begin
        if (divCnt == DIV_LAST) begin
          divNext = '0;
          if (bitCnt == 4'd9) begin
            if (byteCnt == 3'd4) begin
              txNext = 1'b1;
              if (regAddr == ADDR_LAST) begin
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
              end else begin
                addrNext  = regAddr + 5'd1;
                stateNext = SETUP;
              end
            end else begin
              // next byte's start bit directly follows this stop bit
              byteNext  = byteCnt + 3'd1;
              frameNext = frame << 8;
              bitNext   = 4'd0;
              txNext    = 1'b0;
            end
          end else begin
            bitNext = bitCnt + 4'd1;
            txNext  = (bitCnt == 4'd8) ? 1'b1 : curByte[bitCnt[2:0]];
          end
        end else begin
          divNext = divCnt + DW'(1);
        end
      end

      default: begin
        stateNext = IDLE;
        txNext    = 1'b1;
        busyNext  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/sr_reg_dump.md
# sr_reg_dump

Debug-port reader for the schoolRISCV core. On a start pulse it walks the CPU debug register access port (`regAddr` out, `regData` in) over a configured address range and serialises each sampled 32-bit value, tagged with its address, onto a UART 8N1 transmit line. It sits beside the core at board top level and gives a register/PC snapshot stream without a debugger. Address 0 on the debug port returns the PC; addresses 1..31 return x1..x31.

## Interface
Parameters:
- `CLK_DIV`, 4: clock cycles per UART bit; legal range ≥ 2.
- `FIRST_REG`, 0: first debug address dumped (0..31).
- `LAST_REG`, 31: last debug address dumped (0..31). Must satisfy `FIRST_REG` ≤ `LAST_REG`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a dump. Sampled on `clk` in IDLE only.
- `regAddr` out 5: debug address to the core.
- `regData` in 32: debug data from the core; combinational function of `regAddr`.
- `tx` out 1: UART serial output; idle high.
- `busy` out 1: high from start acceptance until the dump completes.
- `done` out 1: one-cycle pulse when the last frame's stop bit ends.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `regAddr`=0, state IDLE, bit/divider counters 0.
- States:
  - IDLE: `tx`=1. If `start`=1, go to SETUP, `regAddr`<=`FIRST_REG`, `busy`<=1.
  - SETUP: one cycle. `regAddr` is stable, so `regData` settles. Next edge: load the 40-bit frame buffer {3'b000, `regAddr`, `regData`}, `tx`<=0 (start bit of byte 0), go to SEND.
  - SEND: 5 bytes, each sent as start(0), data bits LSB first, stop(1). Each bit is held exactly `CLK_DIV` cycles. Bytes go most significant first: address byte, then `regData[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`. Bytes are back-to-back: the next start bit follows the previous stop bit immediately.
  - At the end of the 5th stop bit:
    - If `regAddr`==`LAST_REG`: `done`<=1 for one cycle, `busy`<=0, go to IDLE.
    - Otherwise: `regAddr`<=`regAddr`+1, go to SETUP.
- Each register is sampled atomically at the SETUP→SEND edge. The core keeps running, so different registers may reflect different instants.
- `start` while `busy`=1 is ignored; no queuing.
- `start` held high in the cycle `done` pulses is not accepted that cycle. If it is still high in the next cycle (IDLE), it begins a new dump.
- `regAddr` holds its last value in IDLE.
- Asserting `rst` mid-dump aborts at once, asynchronously: `tx` goes to 1 and all outputs take their reset values. A partial frame is simply truncated.

## Timing
- Let start be accepted at edge k.
- `busy` rises after edge k. The SETUP cycle lies between edges k and k+1. The start bit of the first frame drives `tx` from edge k+1.
- One register frame is 50·`CLK_DIV`+1 clock edges: 1 SETUP plus 50 bits.
- With N = `LAST_REG`−`FIRST_REG`+1, `done`=1 and `busy`=0 are both visible after edge k+N·(50·`CLK_DIV`+1).
- Between frames, the line is high for `CLK_DIV`+1 cycles: the stop bit plus the SETUP cycle.
- No combinational path from `regData` to any output; `tx` is registered.

## Test plan
- Reset: hold `rst`=1 with random inputs. `tx`=1, `busy`=0, `done`=0, `regAddr`=0. Release `rst` with `start`=0: outputs stay unchanged for 100 cycles.
- Single register: `CLK_DIV`=4, `FIRST_REG`=`LAST_REG`=5, model returns 0xDEADBEEF at address 5, pulse `start`.
  - UART decode yields 0x05, 0xDE, 0xAD, 0xBE, 0xEF.
  - Each bit lasts 4 cycles.
  - `done` pulses exactly 201 edges after acceptance.
- Full dump with PC: `CLK_DIV`=4, range 0..31, model returns 0x100+addr for addr≠0 and 0x00000040 for addr 0.
  - 32 frames in ascending address order, first frame 0x00 00 00 00 40.
  - `done` at acceptance+6432 edges.
  - Line high for exactly 5 cycles between frames.
- Sampling point: model changes `regData` for address 3 from 0x11111111 to 0x22222222 one cycle after the SETUP→SEND edge. The frame carries 0x11111111.
- Start while busy: pulse `start` mid-frame 2 of a 4-register dump. The byte stream is identical to the single-start case and `done` pulses once.
- Reset mid-operation: assert `rst` asynchronously during a data bit driving `tx`=0. `tx`=1 within the same cycle, `busy`=0, and no `done` pulse. After release, a new `start` produces a complete, correct dump.
